// File: rtl/instruction_fetch_unit_pkg.sv
// Package: rv_fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_W       : instruction word width
//   PC_STEP       : PC increment per fetched instruction
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Interface: instruction_fetch_unit_if
// Instruction memory request/response bus.
//   imem_req_valid  : fetch request valid          (master -> slave)
//   imem_req_ready  : memory accepts request       (slave -> master)
//   imem_req_addr   : fetch address                (master -> slave)
//   imem_resp_valid : instruction returned, in order, no backpressure (slave -> master)
//   imem_resp_data  : instruction word             (slave -> master)
interface instruction_fetch_unit_if
    import rv_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 64
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Module: fetch_fifo
// Synchronous FIFO holding {pc, instr} entries for decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; takes priority over push/pop
//   rdata      : head entry
//   count      : number of valid entries
//   empty/full : status
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Module: instruction_fetch_unit
// Fetch front end: owns the fetch PC, issues in-order requests to instruction memory,
// buffers returned instructions with their PCs and handles execute-stage redirects.
//   clk, rst_n       : clock, asynchronous active-low reset
//   redirect_valid   : taken branch from execute this cycle
//   redirect_pc      : branch target
//   imem             : instruction memory bus (master side)
//   if_valid/if_ready: decode handshake on the buffer head
//   if_pc/if_instr   : head entry (zero while the buffer is empty)
//   fetch_misaligned : sticky, set by a redirect to a non-word-aligned target
module instruction_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned    XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned    FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    instruction_fetch_unit_if.master imem,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [XLEN-1:0]         if_pc,
    output logic [INSTR_W-1:0]      if_instr,
    output logic                    fetch_misaligned
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned EW = XLEN + INSTR_W;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            misaligned_q, misaligned_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
    logic [EW-1:0]   fifo_rdata;
    logic [CW:0]     in_use;
    logic            req_valid, accept, resp_drop, resp_keep;
    logic            redir_live, redir_ok, redir_bad;

    // Buffered plus in-flight entries never exceed the buffer size, so responses
    // can always be written without backpressure.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_valid = (state_q == RUN) && (in_use < CREDITS);
    assign accept    = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign resp_drop = imem.imem_resp_valid && (drop_cnt_q != '0);
    assign resp_keep = imem.imem_resp_valid && (drop_cnt_q == '0);

    assign redir_live = redirect_valid && (state_q != HALT);
    assign redir_ok   = redir_live && (redirect_pc[1:0] == 2'b00);
    assign redir_bad  = redir_live && (redirect_pc[1:0] != 2'b00);

    // Any live redirect flushes; it also beats a same-cycle dequeue.
    assign fifo_flush = redir_live;
    assign fifo_pop   = !fifo_empty && if_ready && !redir_live;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = accept ? fetch_pc_q + XLEN'(PC_STEP) : fetch_pc_q;
        fifo_push     = resp_keep && (state_q != HALT) && !fifo_full;
        resp_pc_d     = fifo_push ? resp_pc_q + XLEN'(PC_STEP) : resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp_keep);
        drop_cnt_d    = drop_cnt_q - CW'(resp_drop);
        misaligned_d  = misaligned_q;

        case (state_q)
            BOOT:    state_d = RUN;
            DRAIN:   if (drop_cnt_q == '0) state_d = RUN;
            default: ;
        endcase

        if (redir_bad) begin
            misaligned_d = 1'b1;
            fifo_push    = 1'b0;
            state_d      = HALT;
        end else if (redir_ok) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            fifo_push     = 1'b0;
            outstanding_d = '0;
            // Everything still owed by memory is wrong-path: the old in-flight count,
            // plus this cycle's accept, minus a response landing right now.
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(accept)
                          - CW'(imem.imem_resp_valid);
            state_d       = (drop_cnt_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            misaligned_q  <= misaligned_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata ({resp_pc_q, imem.imem_resp_data}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign if_valid         = !fifo_empty;
    assign if_pc            = fifo_empty ? '0 : fifo_rdata[EW-1:INSTR_W];
    assign if_instr         = fifo_empty ? '0 : fifo_rdata[INSTR_W-1:0];
    assign fetch_misaligned = misaligned_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: table-driven steady-state vectors plus
// hand-written redirect, flush and misalignment sequences against a fixed-latency
// in-order memory model.
module tb_instruction_fetch_unit;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misaligned;
    logic        mem_ready = 1'b1;
    logic [1:0]  mem_lat_m1 = 2'd0;  // memory latency minus one

    int checks = 0;
    int errors = 0;

    logic [3:0]  pv;
    logic [63:0] pa [4];

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.XLEN(64)) imem_bus ();

    instruction_fetch_unit #(
        .XLEN       (64),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem             (imem_bus),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .fetch_misaligned (fetch_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Fixed-latency in-order memory: an accepted request reappears as a response
    // mem_lat_m1+1 cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < 4; i++) pa[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= pv[i+1];
                pa[i] <= pa[i+1];
            end
            pv[3] <= 1'b0;
            if (imem_bus.imem_req_valid && mem_ready) begin
                pv[mem_lat_m1] <= 1'b1;
                pa[mem_lat_m1] <= imem_bus.imem_req_addr;
            end
        end
    end

    assign imem_bus.imem_req_ready  = mem_ready;
    assign imem_bus.imem_resp_valid = pv[0];
    assign imem_bus.imem_resp_data  = mem_word(pa[0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [63:0] pc);
        chk({name, " if_valid"}, {63'd0, if_valid}, 64'd1);
        chk({name, " if_pc"}, if_pc, pc);
        chk({name, " if_instr"}, {32'd0, if_instr}, {32'd0, mem_word(pc)});
    endtask

    task automatic check_req(input string name, input logic rv, input logic [63:0] addr);
        chk({name, " req_valid"}, {63'd0, imem_bus.imem_req_valid}, {63'd0, rv});
        chk({name, " req_addr"}, imem_bus.imem_req_addr, addr);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " req_valid"}, {63'd0, imem_bus.imem_req_valid}, 64'd0);
        chk({name, " req_addr"}, imem_bus.imem_req_addr, 64'h0);
        chk({name, " if_valid"}, {63'd0, if_valid}, 64'd0);
        chk({name, " if_pc"}, if_pc, 64'h0);
        chk({name, " if_instr"}, {32'd0, if_instr}, 64'h0);
        chk({name, " misaligned"}, {63'd0, fetch_misaligned}, 64'd0);
    endtask

    // Leaves the bench just after reset release, one edge before BOOT -> RUN.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst_before;
        bit          rdy;
        bit          rv;
        logic [63:0] addr;
        bit          iv;
        logic [63:0] pc;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // Cycle 0 follows reset release. Rows 0-5: streaming with decode ready;
        // rows 6-16: decode stalled, credit limit then one pop frees one request.
        vecs = '{
            '{1'b1, 1'b1, 1'b0, 64'h00, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b1, 64'h00, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b1, 64'h04, 1'b0, 64'h0},
            '{1'b0, 1'b1, 1'b1, 64'h08, 1'b1, 64'h0},
            '{1'b0, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h4},
            '{1'b0, 1'b1, 1'b1, 64'h10, 1'b1, 64'h8},
            '{1'b1, 1'b0, 1'b0, 64'h00, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b1, 64'h00, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b1, 64'h04, 1'b0, 64'h0},
            '{1'b0, 1'b0, 1'b1, 64'h08, 1'b1, 64'h0},
            '{1'b0, 1'b0, 1'b1, 64'h0C, 1'b1, 64'h0},
            '{1'b0, 1'b0, 1'b0, 64'h10, 1'b1, 64'h0},
            '{1'b0, 1'b0, 1'b0, 64'h10, 1'b1, 64'h0},
            '{1'b0, 1'b1, 1'b0, 64'h10, 1'b1, 64'h0},
            '{1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 64'h4},
            '{1'b0, 1'b0, 1'b0, 64'h14, 1'b1, 64'h4},
            '{1'b0, 1'b0, 1'b0, 64'h14, 1'b1, 64'h4}
        };

        mem_ready  = 1'b1;
        mem_lat_m1 = 2'd0;
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_before) do_reset();
            if_ready = vecs[i].rdy;
            @(negedge clk);
            check_req($sformatf("vec%0d", i), vecs[i].rv, vecs[i].addr);
            chk($sformatf("vec%0d if_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].iv});
            if (vecs[i].iv) begin
                chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].pc);
                chk($sformatf("vec%0d if_instr", i), {32'd0, if_instr},
                    {32'd0, mem_word(vecs[i].pc)});
            end
            next_cycle();
        end

        // Redirect with two requests in flight and no response that cycle.
        mem_lat_m1 = 2'd2;
        if_ready   = 1'b0;
        do_reset();
        repeat (8) next_cycle();
        if_ready = 1'b1; next_cycle();
        if_ready = 1'b1; next_cycle();
        if_ready = 1'b0; next_cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h100; mem_ready = 1'b0;
        @(negedge clk);
        chk("t3 pre req_valid", {63'd0, imem_bus.imem_req_valid}, 64'd0);
        check_head("t3 pre", 64'h8);
        next_cycle();
        redirect_valid = 1'b0; mem_ready = 1'b1; mem_lat_m1 = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3 drain%0d req_valid", k), {63'd0, imem_bus.imem_req_valid}, 64'd0);
            chk($sformatf("t3 drain%0d if_valid", k), {63'd0, if_valid}, 64'd0);
            next_cycle();
        end
        @(negedge clk);
        check_req("t3 restart", 1'b1, 64'h100);
        next_cycle();
        @(negedge clk);
        chk("t3 wait if_valid", {63'd0, if_valid}, 64'd0);
        next_cycle();
        @(negedge clk);
        check_head("t3 head0", 64'h100);
        if_ready = 1'b1;
        next_cycle();
        if_ready = 1'b0;
        @(negedge clk);
        check_head("t3 head1", 64'h104);
        next_cycle();

        // Redirect coinciding with an accepted request and a kept response.
        mem_lat_m1 = 2'd1;
        if_ready   = 1'b0;
        do_reset();
        repeat (3) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h200;
        @(negedge clk);
        check_req("t4 redir", 1'b1, 64'h8);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t4 drain%0d req_valid", k), {63'd0, imem_bus.imem_req_valid}, 64'd0);
            chk($sformatf("t4 drain%0d if_valid", k), {63'd0, if_valid}, 64'd0);
            next_cycle();
        end
        @(negedge clk);
        check_req("t4 restart", 1'b1, 64'h200);
        next_cycle();
        @(negedge clk);
        check_req("t4 next", 1'b1, 64'h204);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_head("t4 head", 64'h200);
        next_cycle();

        // Redirect together with a dequeue on a full buffer, then misaligned redirect.
        mem_lat_m1 = 2'd0;
        if_ready   = 1'b0;
        do_reset();
        repeat (6) next_cycle();
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
        @(negedge clk);
        check_head("t5 pre", 64'h0);
        next_cycle();
        if_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5 flushed if_valid", {63'd0, if_valid}, 64'd0);
        check_req("t5 restart", 1'b1, 64'h300);
        next_cycle();
        @(negedge clk);
        chk("t5 wait if_valid", {63'd0, if_valid}, 64'd0);
        next_cycle();
        @(negedge clk);
        check_head("t5 head", 64'h300);
        redirect_valid = 1'b1; redirect_pc = 64'h102;
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h400;
            end else begin
                redirect_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t6 halt%0d req_valid", k), {63'd0, imem_bus.imem_req_valid}, 64'd0);
            chk($sformatf("t6 halt%0d if_valid", k), {63'd0, if_valid}, 64'd0);
            chk($sformatf("t6 halt%0d misaligned", k), {63'd0, fetch_misaligned}, 64'd1);
            next_cycle();
        end
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6 async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
